// File: rtl/spi_mem_seq.sv
// rtl/spi_mem_seq.sv - serial-SRAM command sequencer driving a byte-level SPI shift engine
// Frames each request as opcode, address bytes MSB first, then one data byte.
module spi_mem_seq #(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] READ_CMD  = 8'h03,
    parameter logic [7:0] WRITE_CMD = 8'h02,
    parameter int         TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [7:0]        rsp_rdata,
    output logic              busy,
    output logic              sh_start,
    output logic [7:0]        sh_tx,
    output logic              sh_last,
    input  logic              sh_done,
    input  logic [7:0]        sh_rx
);
    localparam int NAB  = (ADDR_W + 7) / 8;
    localparam int BC_W = (NAB > 1) ? $clog2(NAB) : 1;
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              wait_ph;
    logic              wait_ph_n;
    logic              wr_q;
    logic [NAB*8-1:0]  addr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        rdata_q;
    logic [BC_W-1:0]   byte_cnt;
    logic [WD_W-1:0]   wdog;
    logic              err_q;
    logic              byte_st;
    logic              accept;
    logic              done_ev;
    logic              timeout_ev;
    logic              addr_last;
    logic [7:0]        addr_byte;

    assign byte_st    = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
    assign accept     = (state == S_IDLE) && req_valid;
    assign done_ev    = byte_st && wait_ph && sh_done;
    assign addr_last  = (byte_cnt == '0);
    // A late sh_done in the same cycle as expiry still completes the byte.
    assign timeout_ev = (TIMEOUT > 0) && byte_st && wait_ph && !sh_done
                        && (wdog >= WD_W'(TIMEOUT - 1));

    always_comb begin
        addr_byte = 8'h00;
        for (int i = 0; i < NAB; i++) begin
            if (byte_cnt == BC_W'(i)) begin
                addr_byte = addr_q[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            wait_ph <= 1'b0;
        end else begin
            state   <= state_n;
            wait_ph <= wait_ph_n;
        end
    end

    always_comb begin
        state_n   = state;
        wait_ph_n = wait_ph;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_n   = S_CMD;
                    wait_ph_n = 1'b0;
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (!wait_ph) begin
                    wait_ph_n = 1'b1;
                end else if (sh_done) begin
                    wait_ph_n = 1'b0;
                    case (state)
                        S_CMD:   state_n = S_ADDR;
                        S_ADDR:  if (addr_last) state_n = S_DATA;
                        S_DATA:  state_n = S_RESP;
                        default: state_n = S_IDLE;
                    endcase
                end else if (timeout_ev) begin
                    state_n   = S_RESP;
                    wait_ph_n = 1'b0;
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
            byte_cnt <= '0;
            wdog     <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= (NAB*8)'(req_addr);
                wdata_q <= req_wdata;
                err_q   <= 1'b0;
            end
            // wdog counts cycles since the last sh_start, starting at 1.
            if (byte_st && !wait_ph) begin
                wdog <= WD_W'(1);
            end else if (byte_st) begin
                wdog <= wdog + 1'b1;
            end
            if (done_ev && (state == S_CMD)) begin
                byte_cnt <= BC_W'(NAB - 1);
            end else if (done_ev && (state == S_ADDR) && !addr_last) begin
                byte_cnt <= byte_cnt - 1'b1;
            end
            if (done_ev && (state == S_DATA) && !wr_q) begin
                rdata_q <= sh_rx;
            end
            if (timeout_ev) begin
                err_q   <= 1'b1;
                rdata_q <= 8'h00;
            end
        end
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        sh_start  = byte_st && !wait_ph;
        sh_tx     = 8'h00;
        sh_last   = 1'b0;
        case (state)
            S_CMD:  sh_tx = wr_q ? WRITE_CMD : READ_CMD;
            S_ADDR: sh_tx = addr_byte;
            S_DATA: begin
                sh_tx   = wr_q ? wdata_q : 8'h00;
                sh_last = 1'b1;
            end
            // On abort, a lone sh_last lets the engine release chip-select.
            S_RESP:  sh_last = err_q;
            default: sh_last = 1'b0;
        endcase
        rsp_valid = (state == S_RESP);
        rsp_err   = (state == S_RESP) && err_q;
        rsp_rdata = rdata_q;
    end
endmodule

// File: tb/tb_spi_mem_seq.sv
// tb/tb_spi_mem_seq.sv - scoreboard bench for spi_mem_seq with 8- and 16-bit address instances
module tb_spi_mem_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        mute;
    logic        req_valid [2];
    logic        req_write [2];
    logic [15:0] req_addr  [2];
    logic [7:0]  req_wdata [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic [7:0]  rsp_rdata [2];
    logic        busy      [2];
    logic        sh_start  [2];
    logic [7:0]  sh_tx     [2];
    logic        sh_last   [2];
    logic        sh_done   [2];
    logic [7:0]  sh_rx     [2];

    logic [7:0]  mem [0:65535];
    int          scnt [2];
    int          sbi  [2];
    logic [7:0]  scmd [2];
    logic [15:0] saddr[2];
    logic [7:0]  stx  [2];

    logic [10:0] q_tx [$];
    logic [9:0]  q_rsp[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_rsp_cyc = -1;
    int          first_start_cyc = 0;

    always #5 clk = ~clk;

    spi_mem_seq #(.ADDR_W(8), .READ_CMD(8'h03), .WRITE_CMD(8'h02), .TIMEOUT(16)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0][7:0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .sh_start(sh_start[0]), .sh_tx(sh_tx[0]), .sh_last(sh_last[0]),
        .sh_done(sh_done[0]), .sh_rx(sh_rx[0])
    );

    spi_mem_seq #(.ADDR_W(16), .READ_CMD(8'h03), .WRITE_CMD(8'h02), .TIMEOUT(1024)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .sh_start(sh_start[1]), .sh_tx(sh_tx[1]), .sh_last(sh_last[1]),
        .sh_done(sh_done[1]), .sh_rx(sh_rx[1])
    );

    // Shift engine stub plus serial SRAM: sh_done 4 cycles after sh_start unless muted.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                sh_done[k] <= 1'b0;
                sh_rx[k]   <= 8'h00;
                scnt[k]    <= 0;
                sbi[k]     <= 0;
            end
            mem[16'h0012] <= 8'hA5;
            mem[16'h1234] <= 8'hC3;
        end else begin
            for (int k = 0; k < 2; k++) begin
                sh_done[k] <= 1'b0;
                if (rsp_valid[k]) sbi[k] <= 0;
                if (sh_start[k] && !mute) begin
                    scnt[k] <= 3;
                    stx[k]  <= sh_tx[k];
                end else if (scnt[k] > 0) begin
                    scnt[k] <= scnt[k] - 1;
                    if (scnt[k] == 1) begin
                        sh_done[k] <= 1'b1;
                        sh_rx[k]   <= 8'h00;
                        if (sbi[k] == 0) begin
                            scmd[k]  <= stx[k];
                            saddr[k] <= 16'h0000;
                        end else if (sbi[k] <= k + 1) begin
                            saddr[k] <= {saddr[k][7:0], stx[k]};
                        end else if (scmd[k] == 8'h02) begin
                            mem[saddr[k]] <= stx[k];
                        end else begin
                            sh_rx[k] <= mem[saddr[k]];
                        end
                        sbi[k] <= sbi[k] + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_frame(input int k, input bit w, input logic [15:0] a,
                                input logic [7:0] d, input logic [7:0] rd, input bit to);
        logic kb;
        kb = (k == 1);
        q_tx.push_back({1'b1, kb, 1'b0, (w ? 8'h02 : 8'h03)});
        if (to) begin
            q_rsp.push_back({kb, 1'b1, 8'h00});
        end else begin
            for (int i = k; i >= 0; i--) q_tx.push_back({1'b0, kb, 1'b0, a[i*8 +: 8]});
            q_tx.push_back({1'b0, kb, 1'b1, (w ? d : 8'h00)});
            q_rsp.push_back({kb, 1'b0, rd});
        end
    endtask

    task automatic send(input int k, input bit w, input logic [15:0] a, input logic [7:0] d);
        req_valid[k] = 1'b1;
        req_write[k] = w;
        req_addr[k]  = a;
        req_wdata[k] = d;
        for (int i = 0; i < 200; i++) begin
            if (req_ready[k]) begin
                @(posedge clk);
                #1;
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic drop(input int k);
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 400; i++) begin
            if (q_tx.size() == 0 && q_rsp.size() == 0) return;
            @(negedge clk);
        end
        chk(nm, q_rsp.size(), 0);
        q_tx.delete();
        q_rsp.delete();
    endtask

    task automatic check_reset_outputs(input int k);
        chk("rst_req_ready", req_ready[k], 1);
        chk("rst_busy", busy[k], 0);
        chk("rst_rsp_valid", rsp_valid[k], 0);
        chk("rst_rsp_err", rsp_err[k], 0);
        chk("rst_rsp_rdata", rsp_rdata[k], 8'h00);
        chk("rst_sh_start", sh_start[k], 0);
        chk("rst_sh_tx", sh_tx[k], 8'h00);
        chk("rst_sh_last", sh_last[k], 0);
    endtask

    always @(negedge clk) begin
        logic [10:0] etx;
        logic [9:0]  ers;
        if (!rst) begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (sh_start[k]) begin
                    chk("busy_in_frame", busy[k], 1);
                    chk("ready_in_frame", req_ready[k], 0);
                    if (q_tx.size() == 0) begin
                        chk("unexpected_sh_start", sh_tx[k], 32'hFFFF_FFFF);
                    end else begin
                        etx = q_tx.pop_front();
                        chk("tx_dut", k, etx[9]);
                        chk("sh_last_tx", {sh_last[k], sh_tx[k]}, etx[8:0]);
                        if (etx[10]) begin
                            if (last_rsp_cyc >= 0) chk("b2b_gap_ge2", (cyc - last_rsp_cyc) >= 2, 1);
                            first_start_cyc = cyc;
                        end
                    end
                end
                if (rsp_valid[k]) begin
                    if (q_rsp.size() == 0) begin
                        chk("unexpected_rsp_valid", rsp_rdata[k], 32'hFFFF_FFFF);
                    end else begin
                        ers = q_rsp.pop_front();
                        chk("rsp_dut", k, ers[9]);
                        chk("rsp_err", rsp_err[k], ers[8]);
                        chk("rsp_rdata", rsp_rdata[k], ers[7:0]);
                        if (ers[8]) begin
                            chk("timeout_latency", cyc - first_start_cyc, 16);
                            chk("abort_sh_last", sh_last[k], 1);
                        end
                    end
                    last_rsp_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        mute = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = 16'h0000;
            req_wdata[k] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst = 1'b0;
        @(negedge clk);

        expect_frame(0, 1'b0, 16'h0012, 8'h00, 8'hA5, 1'b0);
        send(0, 1'b0, 16'h0012, 8'h00);
        drop(0);
        wait_done("t1_read");

        expect_frame(0, 1'b1, 16'h0034, 8'h5A, 8'hA5, 1'b0);
        send(0, 1'b1, 16'h0034, 8'h5A);
        drop(0);
        wait_done("t2_write");
        expect_frame(0, 1'b0, 16'h0034, 8'h00, 8'h5A, 1'b0);
        send(0, 1'b0, 16'h0034, 8'h00);
        drop(0);
        wait_done("t2_read");

        expect_frame(0, 1'b1, 16'h0040, 8'h77, 8'h5A, 1'b0);
        expect_frame(0, 1'b0, 16'h0040, 8'h00, 8'h77, 1'b0);
        send(0, 1'b1, 16'h0040, 8'h77);
        send(0, 1'b0, 16'h0040, 8'h00);
        drop(0);
        wait_done("t3_b2b");

        expect_frame(1, 1'b0, 16'h1234, 8'h00, 8'hC3, 1'b0);
        send(1, 1'b0, 16'h1234, 8'h00);
        drop(1);
        wait_done("t4_addr16");

        mute = 1'b1;
        expect_frame(0, 1'b0, 16'h0012, 8'h00, 8'h00, 1'b1);
        send(0, 1'b0, 16'h0012, 8'h00);
        drop(0);
        wait_done("t5_timeout");
        mute = 1'b0;
        expect_frame(0, 1'b0, 16'h0034, 8'h00, 8'h5A, 1'b0);
        send(0, 1'b0, 16'h0034, 8'h00);
        drop(0);
        wait_done("t5_recover");

        expect_frame(0, 1'b0, 16'h0012, 8'h00, 8'hA5, 1'b0);
        send(0, 1'b0, 16'h0012, 8'h00);
        drop(0);
        for (int i = 0; i < 50; i++) begin
            if (sh_start[0] && sh_tx[0] == 8'h12) break;
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        q_tx.delete();
        q_rsp.delete();
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        expect_frame(0, 1'b0, 16'h0012, 8'h00, 8'hA5, 1'b0);
        send(0, 1'b0, 16'h0012, 8'h00);
        drop(0);
        wait_done("t6_after_reset");

        repeat (5) @(negedge clk);
        chk("tx_queue_empty", q_tx.size(), 0);
        chk("rsp_queue_empty", q_rsp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
